// File: rtl/guess_controller_if.sv
// Player/scorer bundle for the guess controller: button pulses and scorer feedback in,
// edit/history/status out. The master side drives buttons and feedback.
interface guess_controller_if;
    logic       digit_up;
    logic       cursor_next;
    logic       submit;
    logic [1:0] fb0, fb1, fb2, fb3;
    logic [2:0] edit0, edit1, edit2, edit3;
    logic [1:0] cursor;
    logic [2:0] history0, history1, history2, history3;
    logic       guess_valid;
    logic       last_turn;
    logic [3:0] turn_cnt;
    logic [2:0] exact_cnt;
    logic       won;
    logic       lost;

    modport master (
        output digit_up, cursor_next, submit, fb0, fb1, fb2, fb3,
        input  edit0, edit1, edit2, edit3, cursor, history0, history1, history2, history3,
               guess_valid, last_turn, turn_cnt, exact_cnt, won, lost
    );

    modport slave (
        input  digit_up, cursor_next, submit, fb0, fb1, fb2, fb3,
        output edit0, edit1, edit2, edit3, cursor, history0, history1, history2, history3,
               guess_valid, last_turn, turn_cnt, exact_cnt, won, lost
    );
endinterface

// File: rtl/guess_controller.sv
// Codebreaker controller: edits a 4-digit guess, commits it to the scorer, samples the
// feedback a fixed delay later and tracks turns, win and loss.
module guess_controller #(
    parameter int unsigned MAX_TURNS  = 10,
    parameter int unsigned NUM_COLORS = 6,
    parameter int unsigned FB_WAIT    = 2
) (
    input  logic               clk,
    input  logic               rst,
    guess_controller_if.slave  bus
);
    localparam int unsigned CW = $clog2(FB_WAIT + 1);

    typedef enum logic [1:0] {StEdit, StScore, StWin, StLose} state_e;

    state_e               state_q, state_d;
    logic [3:0][2:0]      edit_q, edit_d;
    logic [3:0][2:0]      hist_q, hist_d;
    logic [1:0]           cursor_q, cursor_d;
    logic [CW-1:0]        wait_q, wait_d;
    logic [3:0]           turn_q, turn_d;
    logic [2:0]           exact_q, exact_d;
    logic                 gv_q, gv_d;
    logic                 last_q, last_d;
    logic                 won_q, won_d;
    logic                 lost_q, lost_d;
    logic [3:0][1:0]      fb;
    logic [2:0]           exact_now;
    logic [3:0]           turn_inc;

    assign fb       = {bus.fb3, bus.fb2, bus.fb1, bus.fb0};
    assign turn_inc = turn_q + 4'd1;

    // fb value 3 is not a legal score and counts as not exact
    always_comb begin
        exact_now = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (fb[i] == 2'd2) exact_now = exact_now + 3'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        edit_d   = edit_q;
        hist_d   = hist_q;
        cursor_d = cursor_q;
        wait_d   = wait_q;
        turn_d   = turn_q;
        exact_d  = exact_q;
        gv_d     = 1'b0;
        last_d   = last_q;
        won_d    = won_q;
        lost_d   = lost_q;
        unique case (state_q)
            StEdit: begin
                if (bus.submit) begin
                    hist_d  = edit_q;
                    gv_d    = 1'b1;
                    last_d  = (turn_q == 4'(MAX_TURNS - 1));
                    wait_d  = CW'(FB_WAIT);
                    state_d = StScore;
                end else begin
                    // digit_up acts on the old cursor position before any move
                    if (bus.digit_up) begin
                        if (edit_q[cursor_q] == 3'(NUM_COLORS - 1)) edit_d[cursor_q] = 3'd0;
                        else edit_d[cursor_q] = edit_q[cursor_q] + 3'd1;
                    end
                    if (bus.cursor_next) cursor_d = cursor_q + 2'd1;
                end
            end
            StScore: begin
                if (wait_q == CW'(1)) begin
                    wait_d  = '0;
                    exact_d = exact_now;
                    if (turn_q != 4'(MAX_TURNS)) turn_d = turn_inc;
                    if (exact_now == 3'd4) begin
                        won_d   = 1'b1;
                        state_d = StWin;
                    end else if (turn_inc == 4'(MAX_TURNS)) begin
                        lost_d  = 1'b1;
                        state_d = StLose;
                    end else begin
                        last_d  = 1'b0;
                        state_d = StEdit;
                    end
                end else begin
                    wait_d = wait_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StEdit;
            edit_q   <= '0;
            hist_q   <= '0;
            cursor_q <= '0;
            wait_q   <= '0;
            turn_q   <= '0;
            exact_q  <= '0;
            gv_q     <= 1'b0;
            last_q   <= 1'b0;
            won_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            edit_q   <= edit_d;
            hist_q   <= hist_d;
            cursor_q <= cursor_d;
            wait_q   <= wait_d;
            turn_q   <= turn_d;
            exact_q  <= exact_d;
            gv_q     <= gv_d;
            last_q   <= last_d;
            won_q    <= won_d;
            lost_q   <= lost_d;
        end
    end

    assign bus.edit0       = edit_q[0];
    assign bus.edit1       = edit_q[1];
    assign bus.edit2       = edit_q[2];
    assign bus.edit3       = edit_q[3];
    assign bus.cursor      = cursor_q;
    assign bus.history0    = hist_q[0];
    assign bus.history1    = hist_q[1];
    assign bus.history2    = hist_q[2];
    assign bus.history3    = hist_q[3];
    assign bus.guess_valid = gv_q;
    assign bus.last_turn   = last_q;
    assign bus.turn_cnt    = turn_q;
    assign bus.exact_cnt   = exact_q;
    assign bus.won         = won_q;
    assign bus.lost        = lost_q;
endmodule

// File: tb/tb_guess_controller.sv
// Bench for guess_controller: directed button/feedback stimulus pushes expected results
// into a scoreboard; a monitor checks them on each guess_valid and after the feedback delay.
module tb_guess_controller;
    localparam int FB_WAIT = 2;

    typedef struct {
        logic [11:0] hist;   // {h3,h2,h1,h0}
        bit          lt;
        bit          chk;    // 0: turn aborted by reset, skip score check
        int          turn;
        int          exact;
        bit          won;
        bit          lost;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    guess_controller_if bus ();

    guess_controller #(.MAX_TURNS(10), .NUM_COLORS(6), .FB_WAIT(FB_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic press(input bit up, input bit nx, input bit sb_btn);
        @(posedge clk); #1;
        bus.digit_up = up; bus.cursor_next = nx; bus.submit = sb_btn;
        @(posedge clk); #1;
        bus.digit_up = 1'b0; bus.cursor_next = 1'b0; bus.submit = 1'b0;
    endtask

    task automatic set_fb(input logic [1:0] f0, f1, f2, f3);
        bus.fb0 = f0; bus.fb1 = f1; bus.fb2 = f2; bus.fb3 = f3;
    endtask

    task automatic do_turn(input exp_t e);
        sb.push_back(e);
        press(1'b0, 1'b0, 1'b1);
        repeat (FB_WAIT + 1) @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [11:0] h, input bit lt, input int t, input int ex,
                                input bit w, input bit l);
        exp_t e;
        e.hist = h; e.lt = lt; e.chk = 1'b1; e.turn = t; e.exact = ex; e.won = w; e.lost = l;
        return e;
    endfunction

    // Monitor: pops on every guess_valid, then checks the sampled score FB_WAIT cycles later
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.guess_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_guess_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("history", int'({bus.history3, bus.history2, bus.history1,
                                         bus.history0}), int'(e.hist));
                    chk("last_turn_at_gv", int'(bus.last_turn), int'(e.lt));
                    if (e.chk) begin
                        repeat (FB_WAIT) @(negedge clk);
                        chk("turn_cnt", int'(bus.turn_cnt), e.turn);
                        chk("exact_cnt", int'(bus.exact_cnt), e.exact);
                        chk("won", int'(bus.won), int'(e.won));
                        chk("lost", int'(bus.lost), int'(e.lost));
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        bus.digit_up = 1'b0; bus.cursor_next = 1'b0; bus.submit = 1'b0;
        set_fb(2'd0, 2'd0, 2'd0, 2'd0);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_turn", int'(bus.turn_cnt), 0);
        chk("rst_won_lost_gv", int'({bus.won, bus.lost, bus.guess_valid, bus.last_turn}), 0);
        chk("rst_cursor", int'(bus.cursor), 0);
        rst = 1'b0;

        // 7 increments wrap mod 6
        repeat (7) press(1'b1, 1'b0, 1'b0);
        chk("wrap_edit0", int'(bus.edit0), 1);
        chk("wrap_hist0", int'(bus.history0), 0);

        // build 3,1,4,0 using simultaneous up+next twice
        repeat (2) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        repeat (3) press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        chk("cursor_at3", int'(bus.cursor), 3);
        press(1'b0, 1'b1, 1'b0);
        chk("edit_3140", int'({bus.edit3, bus.edit2, bus.edit1, bus.edit0}),
            int'({3'd0, 3'd4, 3'd1, 3'd3}));
        chk("cursor_wrap", int'(bus.cursor), 0);

        // submit+digit_up; fb=2222 outside sample cycle, 2210 at sample; buttons in SCORE
        sb.push_back(mk({3'd0, 3'd4, 3'd1, 3'd3}, 1'b0, 1, 2, 1'b0, 1'b0));
        press(1'b1, 1'b0, 1'b1);
        set_fb(2'd2, 2'd2, 2'd2, 2'd2);
        @(posedge clk); #1;
        set_fb(2'd2, 2'd2, 2'd1, 2'd0);
        bus.digit_up = 1'b1; bus.cursor_next = 1'b1;
        @(posedge clk); #1;
        bus.digit_up = 1'b0; bus.cursor_next = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("score_ignores_edit", int'({bus.edit3, bus.edit2, bus.edit1, bus.edit0}),
            int'({3'd0, 3'd4, 3'd1, 3'd3}));
        chk("score_ignores_cursor", int'(bus.cursor), 0);

        // win, then everything frozen
        set_fb(2'd2, 2'd2, 2'd2, 2'd2);
        do_turn(mk({3'd0, 3'd4, 3'd1, 3'd3}, 1'b0, 2, 4, 1'b1, 1'b0));
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("win_frozen_edit0", int'(bus.edit0), 3);
        chk("win_frozen_turn", int'(bus.turn_cnt), 2);
        chk("win_frozen_won", int'(bus.won), 1);

        // async reset takes effect before the next clock edge
        rst = 1'b1;
        #1;
        chk("async_rst_won", int'(bus.won), 0);
        chk("async_rst_state", int'({bus.turn_cnt, bus.exact_cnt, bus.history0, bus.edit0}), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // reset mid-SCORE aborts the turn before sampling
        press(1'b1, 1'b0, 1'b0);
        e = mk({3'd0, 3'd0, 3'd0, 3'd1}, 1'b0, 0, 0, 1'b0, 1'b0);
        e.chk = 1'b0;
        sb.push_back(e);
        press(1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_hist0", int'(bus.history0), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_sample", int'({bus.turn_cnt, bus.exact_cnt, bus.won}), 0);
        rst = 1'b0;

        // 10 losing turns; odd turns score one exact (fb 3 is not exact)
        for (int i = 0; i < 10; i++) begin
            press(1'b1, 1'b0, 1'b0);
            if (i % 2 == 1) set_fb(2'd3, 2'd3, 2'd1, 2'd2);
            else set_fb(2'd0, 2'd0, 2'd0, 2'd0);
            do_turn(mk({9'd0, 3'((i + 1) % 6)}, i == 9, i + 1, i % 2, 1'b0, i == 9));
        end
        press(1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("lose_turn_sat", int'(bus.turn_cnt), 10);
        chk("lose_last_held", int'(bus.last_turn), 1);
        chk("lose_won", int'(bus.won), 0);

        // win on the final turn: won without lost
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_fb(2'd0, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 9; i++) do_turn(mk(12'd0, 1'b0, i + 1, 0, 1'b0, 1'b0));
        set_fb(2'd2, 2'd2, 2'd2, 2'd2);
        do_turn(mk(12'd0, 1'b1, 10, 4, 1'b1, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        chk("final_win_lost", int'(bus.lost), 0);
        chk("final_win_last", int'(bus.last_turn), 1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
